// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } rx_state_e;

  localparam int MAX_DATA_BITS = 9;
  localparam int MAX_ENTRY_W   = MAX_DATA_BITS + 3;

  // Packs {brk, frame_err, parity_err, data} with the flags placed directly
  // above the data_bits-wide payload; callers truncate to their entry width.
  function automatic logic [MAX_ENTRY_W-1:0] pack_entry(
    input logic                     brk,
    input logic                     frame_err,
    input logic                     parity_err,
    input logic [MAX_DATA_BITS-1:0] data,
    input int                       data_bits
  );
    logic [MAX_ENTRY_W-1:0] flags;
    flags = {{(MAX_ENTRY_W-3){1'b0}}, brk, frame_err, parity_err};
    return {3'b000, data} | (flags << data_bits);
  endfunction

  // Legal parameter ranges for the receiver; checked at elaboration.
  function automatic bit params_ok(
    input int oversample,
    input int data_bits,
    input int parity,
    input int stop_bits,
    input int fifo_depth
  );
    bit ok;
    ok = 1'b1;
    if (oversample < 8 || (oversample % 2) != 0) ok = 1'b0;
    if (data_bits < 5 || data_bits > MAX_DATA_BITS) ok = 1'b0;
    if (parity < 0 || parity > 2) ok = 1'b0;
    if (stop_bits < 1 || stop_bits > 2) ok = 1'b0;
    if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with first-word fall-through read port.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign wr_en = push && (!full || rd_en);
  // Head reads as zero while empty so the outputs have a defined value after reset.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; power-of-2 depth lets pointers wrap freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority voting, error/break detection
// and a frame FIFO behind a valid/ready handshake.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uartRx,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid,
  input  logic                 rxReady,
  output logic                 parityError,
  output logic                 frameError,
  output logic                 breakFlag,
  output logic                 breakDetect,
  output logic                 overrun,
  input  logic                 clearOverrun,
  output logic                 rxBusy
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int EW  = DATA_BITS + 3;
  localparam int M   = OVERSAMPLE / 2;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] SC_LO     = SW'(M - 1);
  localparam logic [SW-1:0] SC_MID    = SW'(M);
  localparam logic [SW-1:0] SC_HI     = SW'(M + 1);
  localparam logic [SW-1:0] SC_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam parity_e       PMODE     = parity_e'(PARITY);

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx_os: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE (DIV < 1)");
  end
  if (!params_ok(OVERSAMPLE, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_param_chk
    $error("uart_rx_os: parameter out of range");
  end

  logic                 sync_p0;
  logic                 sync_p1;
  logic                 rxS;
  rx_state_e            state;
  rx_state_e            next_state;
  logic [TW-1:0]        tcnt;
  logic                 tick;
  logic [SW-1:0]        sc;
  logic                 s_lo;
  logic                 s_mid;
  logic                 maj;
  logic                 decide;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 exp_par;
  logic                 par_err;
  logic                 frame_err;
  logic                 seen_one;
  logic                 break_cond;
  logic                 push;
  logic                 brk_now;
  logic [EW-1:0]        entry;
  logic [EW-1:0]        head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 drop;
  logic                 break_det;
  logic                 ovr;

  // Two-flop synchroniser; flops rest high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= uartRx;
      sync_p1 <= sync_p0;
    end
  end
  assign rxS = sync_p1;

  // Oversample tick divider, parked at zero while idle so each frame starts phase-aligned
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) tcnt <= '0;
    else if (tcnt == TICK_LAST)   tcnt <= '0;
    else                          tcnt <= tcnt + 1'b1;
  end
  assign tick = (state != S_IDLE) && (tcnt == TICK_LAST);

  // Sample counter within a bit, capturing the two early votes around the midpoint
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) begin
      sc    <= '0;
      s_lo  <= 1'b1;
      s_mid <= 1'b1;
    end else if (tick) begin
      sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
      if (sc == SC_LO)  s_lo  <= rxS;
      if (sc == SC_MID) s_mid <= rxS;
    end
  end
  assign decide  = tick && (sc == SC_HI);
  assign maj     = (s_lo & s_mid) | (s_lo & rxS) | (s_mid & rxS);
  assign exp_par = (PMODE == ODD) ? ~^shreg : ^shreg;
  // Break needs an all-zero frame: data, parity (if any) and every stop bit low.
  assign break_cond = (shreg == '0) && !seen_one && !maj;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; the entry is pushed on the final stop-bit decision
  always_comb begin
    next_state = state;
    push       = 1'b0;
    brk_now    = 1'b0;
    case (state)
      S_IDLE:       if (!rxS) next_state = S_START;
      S_START:      if (decide) next_state = maj ? S_IDLE : S_DATA;
      S_DATA:       if (decide && bcnt == DATA_LAST)
                      next_state = (PMODE != NONE) ? S_PARITY : S_STOP;
      S_PARITY:     if (decide) next_state = S_STOP;
      S_STOP: begin
        if (decide && bcnt == STOP_LAST) begin
          push = 1'b1;
          if (break_cond) begin
            brk_now    = 1'b1;
            next_state = S_BREAK_WAIT;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      S_BREAK_WAIT: if (rxS) next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  // Per-frame bit counter and error accumulation, cleared whenever the FSM idles
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) begin
      bcnt      <= '0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      seen_one  <= 1'b0;
    end else if (decide) begin
      bcnt <= (next_state != state) ? '0 : bcnt + 1'b1;
      if (state == S_PARITY) begin
        par_err  <= (maj != exp_par);
        seen_one <= seen_one | maj;
      end
      if (state == S_STOP) begin
        frame_err <= frame_err | ~maj;
        seen_one  <= seen_one | maj;
      end
    end
  end

  // Data shift register, LSB first; fully rewritten each frame so it needs no reset
  always_ff @(posedge clk) begin
    if (decide && state == S_DATA) shreg <= {maj, shreg[DATA_BITS-1:1]};
  end

  assign entry = EW'(pack_entry(brk_now, frame_err | ~maj, par_err,
                                MAX_DATA_BITS'(shreg), DATA_BITS));

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rxValid     = !fifo_empty;
  assign pop         = rxValid && rxReady;
  assign drop        = push && fifo_full && !pop;
  assign rxData      = head[DATA_BITS-1:0];
  assign parityError = head[DATA_BITS];
  assign frameError  = head[DATA_BITS+1];
  assign breakFlag   = head[DATA_BITS+2];
  assign breakDetect = break_det;
  assign overrun     = ovr;
  assign rxBusy      = (state != S_IDLE);

  // Break pulse and sticky overrun; a drop in the clearing cycle keeps overrun set
  always_ff @(posedge clk) begin
    if (reset) begin
      break_det <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      break_det <= brk_now;
      if (drop)              ovr <= 1'b1;
      else if (clearOverrun) ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: frame-level reference model plus
// directed scenarios with literal expected entries.
module tb_uart_rx_os;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int OS       = 16;
  localparam int FD       = 4;
  localparam int BIT_CYC  = CLK_FREQ / BAUD;

  logic       clk          = 1'b0;
  logic       reset        = 1'b1;
  logic       uartRx       = 1'b1;
  logic       rxReady      = 1'b0;
  logic       clearOverrun = 1'b0;
  logic [7:0] rxData;
  logic       rxValid;
  logic       parityError;
  logic       frameError;
  logic       breakFlag;
  logic       breakDetect;
  logic       overrun;
  logic       rxBusy;

  int         checks   = 0;
  int         failures = 0;
  logic [10:0] expq[$];
  bit         chk_en   = 1'b0;
  bit         exp_ovr  = 1'b0;
  int         brk_cnt  = 0;
  int         busy_cnt = 0;

  uart_rx_os #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .OVERSAMPLE (OS),
    .DATA_BITS  (8),
    .PARITY     (1),
    .STOP_BITS  (1),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uartRx       (uartRx),
    .rxData       (rxData),
    .rxValid      (rxValid),
    .rxReady      (rxReady),
    .parityError  (parityError),
    .frameError   (frameError),
    .breakFlag    (breakFlag),
    .breakDetect  (breakDetect),
    .overrun      (overrun),
    .clearOverrun (clearOverrun),
    .rxBusy       (rxBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: what a frame must produce, straight from the frame-level rules.
  function automatic logic [10:0] model_entry(input logic [7:0] d, input logic pbit, input logic stop);
    logic pe, fe, brk;
    pe  = (pbit != ^d);
    fe  = !stop;
    brk = (d == 8'h00) && !pbit && !stop;
    return {brk, fe, pe, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    uartRx = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic drive_bit(input logic b, input bit flip);
    for (int k = 0; k < BIT_CYC; k++) begin
      uartRx = (flip && k == 8) ? ~b : b;
      cyc();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input bit flip);
    drive_bit(1'b0, flip);
    for (int i = 0; i < 8; i++) drive_bit(d[i], flip);
    drive_bit(pbit, flip);
    drive_bit(stop, flip);
    uartRx = 1'b1;
  endtask

  task automatic send_lit(input logic [7:0] d, input logic pbit, input logic stop,
                          input bit flip, input logic [10:0] req);
    expq.push_back(req);
    send_frame(d, pbit, stop, flip);
  endtask

  task automatic send_model(input logic [7:0] d, input logic pbit, input logic stop);
    if (expq.size() < FD) expq.push_back(model_entry(d, pbit, stop));
    else exp_ovr = 1'b1;
    send_frame(d, pbit, stop, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    rxReady = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 400) begin
      cyc();
      n++;
    end
    check(name, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rxValid"}, 32'(rxValid), 32'd0);
    check({tag, "_rxData"}, 32'(rxData), 32'd0);
    check({tag, "_parityError"}, 32'(parityError), 32'd0);
    check({tag, "_frameError"}, 32'(frameError), 32'd0);
    check({tag, "_breakFlag"}, 32'(breakFlag), 32'd0);
    check({tag, "_breakDetect"}, 32'(breakDetect), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_rxBusy"}, 32'(rxBusy), 32'd0);
  endtask

  // Compare process: whenever the head is valid it must equal the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (breakDetect) brk_cnt++;
      if (rxBusy) busy_cnt++;
      if (chk_en && !reset && rxValid) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_entry: actual=%0h required=none",
                   {breakFlag, frameError, parityError, rxData});
        end else begin
          check("head_entry", 32'({breakFlag, frameError, parityError, rxData}), 32'(expq[0]));
          if (rxReady) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    logic [7:0] d;
    logic pbit, stop;
    int gap;

    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    chk_en = 1'b1;
    cyc();

    // 1: clean frame then back-to-back frame
    rxReady = 1'b1;
    idle(5);
    send_lit(8'h5A, 1'b0, 1'b1, 1'b0, 11'h05A);
    send_lit(8'hA5, 1'b0, 1'b1, 1'b0, 11'h0A5);
    wait_drain("t1_drain");

    // 2: parity error, then framing error with good parity
    idle(5);
    send_lit(8'h5A, 1'b1, 1'b1, 1'b0, 11'h15A);
    idle(5);
    send_lit(8'h07, 1'b1, 1'b0, 1'b0, 11'h207);
    idle(40);
    wait_drain("t2_drain");

    // 3: short glitch is a false start; single flipped samples are voted out
    base = busy_cnt;
    uartRx = 1'b0;
    repeat (3) cyc();
    idle(20);
    check("glitch_busy_seen", 32'(busy_cnt > base), 32'd1);
    check("glitch_busy_back", 32'(rxBusy), 32'd0);
    check("glitch_no_entry", 32'(rxValid), 32'd0);
    send_lit(8'h3C, 1'b0, 1'b1, 1'b1, 11'h03C);
    wait_drain("t3_drain");

    // 4: break held for 20 bit times, then a normal frame
    idle(10);
    base = brk_cnt;
    expq.push_back(11'h600);
    uartRx = 1'b0;
    for (int k = 0; k < 20 * BIT_CYC; k++) begin
      cyc();
      if (k == 300) check("break_wait_busy", 32'(rxBusy), 32'd1);
    end
    check("break_entry_seen", 32'(expq.size()), 32'd0);
    check("break_pulses", 32'(brk_cnt - base), 32'd1);
    idle(32);
    send_lit(8'h11, 1'b0, 1'b1, 1'b0, 11'h011);
    wait_drain("t4_drain");

    // 5: overrun with a stalled consumer, clear it, then drain in order
    rxReady = 1'b0;
    exp_ovr = 1'b0;
    idle(5);
    for (int v = 0; v < 5; v++) begin
      if (v == 4) check("ovr_before_drop", 32'(overrun), 32'd0);
      send_model(8'(v), ^(8'(v)), 1'b1);
    end
    idle(3);
    @(negedge clk);
    check("ovr_set", 32'(overrun), 32'(exp_ovr));
    check("ovr_full_valid", 32'(rxValid), 32'd1);
    check("ovr_queue_depth", 32'(expq.size()), 32'd4);
    cyc();
    clearOverrun = 1'b1;
    cyc();
    clearOverrun = 1'b0;
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 32'd0);
    exp_ovr = 1'b0;
    cyc();
    wait_drain("t5_drain");
    cyc();
    @(negedge clk);
    check("t5_empty", 32'(rxValid), 32'd0);
    cyc();

    // 6: reset mid-frame discards the partial frame and empties the FIFO
    rxReady = 1'b0;
    idle(5);
    send_lit(8'h33, 1'b0, 1'b1, 1'b0, 11'h033);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 0, 1'b0);
    chk_en = 1'b0;
    reset  = 1'b1;
    uartRx = 1'b1;
    expq.delete();
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    chk_en  = 1'b1;
    rxReady = 1'b1;
    idle(20);
    send_lit(8'h42, 1'b0, 1'b1, 1'b0, 11'h042);
    wait_drain("t6_drain");

    // Randomised frames against the model, with occasional consumer stalls
    exp_ovr = 1'b0;
    for (int f = 0; f < 30; f++) begin
      d    = 8'($urandom);
      pbit = (^d) ^ ($urandom_range(0, 4) == 0);
      stop = ($urandom_range(0, 6) != 0);
      if (d == 8'h00) stop = 1'b1;
      gap  = stop ? int'($urandom_range(0, 12)) : 40;
      rxReady = ($urandom_range(0, 2) != 0);
      idle(6 + gap);
      send_model(d, pbit, stop);
      if (!stop) idle(40);
      @(negedge clk);
      check("rand_overrun", 32'(overrun), 32'(exp_ovr));
      cyc();
    end
    wait_drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Next-generation UART receiver. It adds oversampling with 3-sample majority voting, and parametrised data bits, parity and stop bits. It detects parity, framing and break errors, and buffers received frames in a FIFO behind a valid/ready handshake. It sits between the pad-side serial input and the command/packet parser, replacing the fixed 8-bit receiver, which had no buffering.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in baud.
- OVERSAMPLE, 16, samples per bit; must be even and at least 8.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 1, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- FIFO_DEPTH, 4, number of frame entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- uartRx  in  1  asynchronous serial line; idle level is high.
- rxData  out  DATA_BITS  data of the FIFO head entry, LSB = first bit received.
- rxValid  out  1  FIFO head entry is valid.
- rxReady  in  1  consumer accepts the head entry when rxValid && rxReady.
- parityError  out  1  parity flag of the head entry; qualified by rxValid.
- frameError  out  1  stop-bit flag of the head entry; qualified by rxValid.
- breakFlag  out  1  break flag of the head entry; qualified by rxValid.
- breakDetect  out  1  one-cycle pulse when a break condition is recognised.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- clearOverrun  in  1  clears overrun on the next clock edge.
- rxBusy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: FSM returns to IDLE and FIFO empties.
  - rxValid, overrun, breakDetect and rxBusy reset to 0.
  - rxData and all head-entry flags reset to 0.
  - Synchroniser flops reset to 1.
  - Reset asserted mid-frame discards the partial frame; nothing is pushed.
- Input synchronisation: 2-flop synchroniser. All logic uses the synchronised signal rxS.
- Oversample tick:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), with an elaboration check that DIV >= 1.
  - The tick counter is held at 0 in IDLE and produces a one-cycle tick every DIV clocks otherwise.
- Sample counter: sc runs 0..OVERSAMPLE-1 per bit and increments on each tick.
  - Bit value = majority of rxS at sc = M-1, M and M+1, where M = OVERSAMPLE/2.
  - The bit decision is taken at sc = M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: rxS == 0 -> START, with sc and bit count cleared.
  - START: at the decision point, majority 0 -> DATA; majority 1 is a false start -> IDLE with no push.
  - DATA: DATA_BITS bits shifted in LSB-first, one per bit period. After the last bit -> PARITY if PARITY != 0, else STOP.
  - PARITY: the received bit is compared with the expected value.
    - Even mode: expected = ^data.
    - Odd mode: expected = ~^data.
    - A mismatch sets parityErr.
  - STOP: each stop bit is decided at its midpoint. Any stop bit sampled 0 sets frameErr.
  - After the last stop decision, the entry is pushed that same cycle. The FSM goes to IDLE immediately, without waiting out the rest of the stop bit, so it can resync on the next start edge.
- Break:
  - Condition: data == 0, parity bit == 0 (if enabled) and every stop bit == 0.
  - Actions: breakDetect pulses for 1 cycle; the entry is pushed with brk = 1 and frameErr = 1; FSM -> BREAK_WAIT.
  - BREAK_WAIT stays until rxS == 1, then -> IDLE. No further frames are produced while the line stays low.
- FIFO entry: {brk, frameErr, parityErr, data}.
  - First-word fall-through: rxValid and the head fields are valid the cycle after the push into an empty FIFO.
  - Pop when rxValid && rxReady.
- Push and pop rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - A push while full with no pop drops the frame and sets overrun to 1.
- Overrun clearing: overrun is cleared by clearOverrun. If clearOverrun and a new drop occur in the same cycle, overrun stays 1.
- Empty FIFO: when empty, rxValid = 0 and rxReady is ignored.
- Counter widths: $clog2-sized, with a minimum width of 1.

Decomposition:
- Package uart_pkg holds:
  - parity_e: NONE = 0, EVEN = 1, ODD = 2.
  - rx_state_e.
  - A parameterised entry-packing helper.
  - Elaboration assertions for the parameter ranges.
- Sub-module sync_fifo: generic, parameters WIDTH and DEPTH; push/pop/full/empty; first-word fall-through. It is reused later by the TX path.

Test Plan:
Bench parameters: CLK_FREQ = 1_600_000, BAUD_RATE = 100_000, OVERSAMPLE = 16 (DIV = 1, 16 clk per bit), 8 data bits, even parity, 1 stop bit, FIFO_DEPTH = 4.
1. Send 0x5A with parity bit 0 and stop bit 1, rxReady = 1 -> rxValid pulses once with rxData = 0x5A and all error flags 0. Then send 0xA5 back-to-back with no idle gap -> second entry is 0xA5.
2. Send 0x5A with parity bit 1 -> entry 0x5A with parityError = 1. Send 0x07 with parity bit 1 and stop bit 0 -> entry 0x07 with parityError = 0 and frameError = 1.
3. Drive a 3-clk low glitch on an idle line -> no push, rxBusy returns to 0 within 1 bit time. Flip single samples at M-1 of every bit of 0x3C -> rxData = 0x3C (majority vote rejects the flips).
4. Hold the line low for 20 bit times -> exactly one breakDetect pulse and one entry {brk = 1, frameErr = 1, data = 0x00}. No further entries until the line goes high. A following 0x11 is received correctly.
5. With rxReady = 0, send 0x00..0x04 -> FIFO holds 0x00..0x03 and overrun = 1. Pulse clearOverrun -> overrun = 0. Pop 4 -> data is 0x00, 0x01, 0x02, 0x03 in order, then rxValid = 0.
6. Assert reset midway through the data bits of 0x81 -> no entry pushed, all outputs 0. A frame 0x42 sent after reset deasserts is received correctly.
